// File: rtl/decoder_scan_seq.sv
// Channel scan sequencer feeding a SEL_W-to-2**SEL_W select decoder.
// Optional feature: define SCAN_BLANK_EN to insert a 1-cycle blanking slot at every channel advance.
module decoder_scan_seq #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [(2**SEL_W)-1:0]   mask,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [SEL_W-1:0]        sel,
  output logic                    sel_valid,
  output logic                    wrap
);

  localparam int unsigned NCH = 2**SEL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [SEL_W-1:0]     sel_d, nxt_sel, low_sel;
  logic                 sel_valid_d, wrap_d;
  logic [DWELL_W-1:0]   cnt, cnt_d, dwell_q, dwell_q_d, dwell_eff;
  logic                 exit_cond, adv;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign exit_cond = !en || (mask == '0);
  // Advance on dwell expiry or when the current channel is masked off mid-dwell
  assign adv       = (cnt == dwell_q - DWELL_W'(1)) || !mask[sel];

  // Next enabled channel after sel (wrapping, falls back to sel) and lowest enabled channel
  always_comb begin
    nxt_sel = sel;
    low_sel = '0;
    for (int i = NCH - 1; i >= 1; i--) begin
      if (mask[SEL_W'(32'(sel) + 32'(i))]) nxt_sel = SEL_W'(32'(sel) + 32'(i));
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) low_sel = SEL_W'(i);
    end
  end

  // State register plus registered outputs and datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      sel_valid <= 1'b0;
      wrap      <= 1'b0;
      cnt       <= '0;
      dwell_q   <= DWELL_W'(1);
    end else begin
      state     <= state_d;
      sel       <= sel_d;
      sel_valid <= sel_valid_d;
      wrap      <= wrap_d;
      cnt       <= cnt_d;
      dwell_q   <= dwell_q_d;
    end
  end

  // Next-state logic; leaving the scan takes priority over advancing
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (!exit_cond) state_d = SCAN;
      SCAN: begin
        if (exit_cond) state_d = IDLE;
`ifdef SCAN_BLANK_EN
        else if (adv) state_d = BLANK;
`endif
      end
`ifdef SCAN_BLANK_EN
      BLANK: state_d = exit_cond ? IDLE : SCAN;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and dwell counter
  always_comb begin
    sel_d       = sel;
    sel_valid_d = sel_valid;
    wrap_d      = 1'b0;
    cnt_d       = cnt;
    dwell_q_d   = dwell_q;
    case (state)
      IDLE: begin
        if (!exit_cond) begin
          sel_d       = low_sel;
          sel_valid_d = 1'b1;
          cnt_d       = '0;
          dwell_q_d   = dwell_eff;
        end else begin
          sel_valid_d = 1'b0;
        end
      end
      SCAN: begin
        if (exit_cond) begin
          sel_valid_d = 1'b0;
          cnt_d       = '0;
        end else if (adv) begin
          sel_d     = nxt_sel;
          cnt_d     = '0;
          dwell_q_d = dwell_eff;
          wrap_d    = (nxt_sel <= sel);
`ifdef SCAN_BLANK_EN
          sel_valid_d = 1'b0;
`else
          sel_valid_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt + DWELL_W'(1);
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        sel_valid_d = !exit_cond;
        cnt_d       = '0;
      end
`endif
      default: begin
        sel_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq: a behavioural model pushes expected outputs per cycle.
module tb_decoder_scan_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_valid;
  logic       wrap;

  int n_vec = 0;
  int n_err = 0;

  // model state: 0 idle, 1 scan, 2 blank; rem = scan cycles left on current channel
  int         m_st = 0;
  logic [2:0] m_sel = '0;
  logic       m_valid = 1'b0;
  logic       m_wrap = 1'b0;
  int         m_rem = 1;

  logic [4:0] sbq[$];

  decoder_scan_seq #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mask(mask), .dwell(dwell),
    .sel(sel), .sel_valid(sel_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int deff();
    return (dwell == 0) ? 1 : int'(dwell);
  endfunction

  task automatic model_update();
    int n;
    if (!rst_n) begin
      m_st = 0; m_sel = '0; m_valid = 1'b0; m_wrap = 1'b0; m_rem = 1;
    end else if (m_st == 0) begin
      m_wrap = 1'b0;
      if (en && mask != 0) begin
        for (int j = 7; j >= 0; j--) if (mask[j]) m_sel = 3'(j);
        m_valid = 1'b1; m_rem = deff(); m_st = 1;
      end else begin
        m_valid = 1'b0;
      end
    end else if (!en || mask == 0) begin
      m_st = 0; m_valid = 1'b0; m_wrap = 1'b0;
    end else if (m_st == 2) begin
      m_st = 1; m_valid = 1'b1; m_wrap = 1'b0;
    end else if (m_rem == 1 || !mask[m_sel]) begin
      n = int'(m_sel);
      for (int d = 8; d >= 1; d--) if (mask[(int'(m_sel) + d) % 8]) n = (int'(m_sel) + d) % 8;
      m_wrap = (n <= int'(m_sel));
      m_sel  = 3'(n);
      m_rem  = deff();
`ifdef SCAN_BLANK_EN
      m_st = 2; m_valid = 1'b0;
`else
      m_valid = 1'b1;
`endif
    end else begin
      m_rem--; m_wrap = 1'b0;
    end
  endtask

  // Apply current inputs for one clock, then compare against the scoreboard entry
  task automatic cycle();
    logic [4:0] e;
    model_update();
    sbq.push_back({m_sel, m_valid, m_wrap});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sel", 32'(sel), 32'(e[4:2]));
    chk("sel_valid", 32'(sel_valid), 32'(e[1]));
    chk("wrap", 32'(wrap), 32'(e[0]));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mask = 8'hFF; dwell = 8'd2;
    #1;
    // reset held with scan requested
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_valid", 32'(sel_valid), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
    end
    rst_n = 1'b1;

    // full mask, dwell 2
    for (int i = 0; i < 18; i++) begin
      cycle();
`ifndef SCAN_BLANK_EN
      chk("t2_sel", 32'(sel), 32'((i / 2) % 8));
      chk("t2_wrap", 32'(wrap), 32'(i == 16));
`endif
    end
    en = 1'b0; cycle();
    chk("idle_valid", 32'(sel_valid), 32'd0);

    // two channels, dwell 1 then dwell 0
    en = 1'b1; mask = 8'b0010_0100; dwell = 8'd1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        cycle();
`ifndef SCAN_BLANK_EN
        chk("t3_sel", 32'(sel), (i % 2 == 1) ? 32'd5 : 32'd2);
        chk("t3_wrap", 32'(wrap), 32'((i % 2 == 0) && (i >= 2 || k == 1)));
`endif
      end
      dwell = 8'd0;
    end
    en = 1'b0; cycle();

    // mask bit of active channel dropped mid-dwell, then disable
    en = 1'b1; mask = 8'hFF; dwell = 8'd4;
    for (int i = 1; i <= 14; i++) cycle();
    mask = 8'hF7; cycle();
`ifndef SCAN_BLANK_EN
    chk("t4_sel", 32'(sel), 32'd4);
`endif
    en = 1'b0; cycle();
`ifndef SCAN_BLANK_EN
    chk("t4_hold", 32'(sel), 32'd4);
`endif
    chk("t4_valid", 32'(sel_valid), 32'd0);

    // single channel, dwell 3, then mask cleared
    en = 1'b1; mask = 8'b0000_1000; dwell = 8'd3;
    for (int i = 1; i <= 10; i++) begin
      cycle();
`ifndef SCAN_BLANK_EN
      chk("t5_sel", 32'(sel), 32'd3);
      chk("t5_wrap", 32'(wrap), 32'(i == 4 || i == 7 || i == 10));
`endif
    end
    mask = 8'h00; cycle();
    chk("t5_valid", 32'(sel_valid), 32'd0);

`ifdef SCAN_BLANK_EN
    // blanking slot on every advance, then reset while blanked
    begin
      logic [3:0] exp6 [6];
      exp6 = '{4'b0001, 4'b0001, 4'b0010, 4'b0011, 4'b0011, 4'b0000};
      mask = 8'h03; dwell = 8'd2;
      for (int i = 0; i < 6; i++) begin
        cycle();
        chk("t6_sv", 32'({sel, sel_valid}), 32'(exp6[i]));
      end
      rst_n = 1'b0; cycle();
      chk("t6_rst", 32'({sel, sel_valid, wrap}), 32'd0);
      rst_n = 1'b1;
    end
`endif

    // random traffic incl. mid-dwell changes and occasional reset
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      en    = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       mask = 8'h00;
          1:       mask = 8'(1 << $urandom_range(0, 7));
          default: mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 5) == 0) dwell = 8'($urandom_range(0, 4));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
